apb_master: RTL
===============

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 13: APB address width.
REQ-002 SHALL have parameter DATA_W, default 32: APB data width; strobe width is DATA_W/8.
REQ-003 SHALL have parameter TIMEOUT, default 16: maximum ACCESS cycles before abort; 0 disables the timeout.
REQ-004 SHALL have port pclk  in  1: single clock; all logic rising-edge.
REQ-005 SHALL have port preset  in  1: reset, asynchronous, active-high.
REQ-006 SHALL have ports cmd_valid in 1, cmd_ready out 1, cmd_write in 1, cmd_addr in ADDR_W, cmd_wdata in DATA_W, cmd_strb in DATA_W/8: command request channel.
REQ-007 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_rdata out DATA_W, rsp_err out 1, rsp_timeout out 1: response channel.
REQ-008 SHALL have ports psel out 1, penable out 1, pwrite out 1, paddr out ADDR_W, pwdata out DATA_W, pstrb out DATA_W/8: APB requester outputs.
REQ-009 SHALL have ports pready in 1, prdata in DATA_W, pslverr in 1: APB completer inputs.

Function
REQ-010 SHALL implement the states IDLE, SETUP, ACCESS and RESP.
REQ-011 SHALL drive cmd_ready high only in IDLE; a command is accepted on a cycle with cmd_valid and cmd_ready both high.
REQ-012 SHALL, on acceptance, latch write/addr/wdata/strb and go to SETUP; a cmd_valid seen outside IDLE is ignored until IDLE.
REQ-013 SHALL, on acceptance with cmd_addr[1:0] != 0, skip the bus and go to RESP with rsp_err=1, rsp_timeout=0, rsp_rdata=0; psel never asserts.
REQ-014 SHALL in SETUP drive psel=1, penable=0 and go to ACCESS after exactly one cycle.
REQ-015 SHALL in ACCESS drive psel=1 and penable=1.
REQ-016 SHALL hold paddr, pwrite, pwdata and pstrb stable from SETUP until the cycle pready is sampled high.
REQ-017 SHALL drive pwdata=0 and pstrb=0 for reads.
REQ-018 SHALL, on pready=1 in ACCESS: capture prdata (reads only; writes return 0) and pslverr into rsp_rdata and rsp_err, then go to RESP.
REQ-019 SHALL deassert psel and penable in the cycle after completion.
REQ-020 SHALL ignore pready, pslverr and prdata outside ACCESS.
REQ-021 SHALL count ACCESS cycles from 1 while TIMEOUT>0; if the count reaches TIMEOUT with pready low, it SHALL abort to RESP with rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-022 SHALL in RESP hold rsp_valid=1 with stable rsp_* until rsp_ready=1, then go to IDLE.
REQ-023 SHALL deliver a zero-wait-state transfer with latency: accept at cycle N, SETUP at N+1, ACCESS at N+2, rsp_valid at N+3.
REQ-024 SHALL permit at most one outstanding transfer.
REQ-025 SHALL hold paddr, pwrite, pwdata and pstrb at their last values while in IDLE.

Reset
REQ-026 SHALL, while preset=1, force state=IDLE and drive every output to 0, including cmd_ready.
REQ-027 SHALL, when reset is asserted mid-transfer, drop psel/penable immediately (asynchronously), produce no response, and clear the timeout counter.
REQ-028 SHALL raise cmd_ready in the first clock edge after preset deasserts.

Structure
REQ-029 SHALL take the following from shared package apb_pkg: the state enum; the register address constants TX_DATA 0x000, RX_DATA 0x004, CFG 0x008, CTRL 0x00C, STT 0x010; and the default widths.
REQ-030 SHALL place the timeout counter in the sub-module apb_master_timer, with inputs clear/enable and output expired.

Verification
REQ-031 SHALL test: write 0xA5 to 0x000, strb=0x1, pready tied high -> psel at N+1, penable at N+2, rsp_valid at N+3, rsp_err=0, pwdata=0xA5 throughout.
REQ-032 SHALL test: read 0x010, pready after 3 wait states, prdata=0x5 -> rsp_rdata=0x5, pstrb=0, paddr stable for all 5 bus cycles.
REQ-033 SHALL test: write 0x014, completer returns pslverr=1 with pready -> rsp_err=1, rsp_timeout=0.
REQ-034 SHALL test: read 0x008, pready held low -> abort after 16 ACCESS cycles with rsp_timeout=1, rsp_err=1, rsp_rdata=0, psel low the next cycle.
REQ-035 SHALL test: cmd_addr=0x002 -> psel never asserts, rsp_err=1; then rsp_ready low for 5 cycles -> rsp fields stable and cmd_ready=0 throughout.
REQ-036 SHALL test: preset asserted during ACCESS -> psel=penable=0 before the next edge, no rsp_valid, and the next command completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared definitions for the APB requester: FSM state encoding, register map
// constants for the peripheral block and the default bus geometry.
package apb_pkg;

   localparam int APB_ADDR_W  = 13;
   localparam int APB_DATA_W  = 32;
   localparam int APB_TIMEOUT = 16;

   localparam logic [APB_ADDR_W-1:0] TX_DATA = 13'h000;
   localparam logic [APB_ADDR_W-1:0] RX_DATA = 13'h004;
   localparam logic [APB_ADDR_W-1:0] CFG     = 13'h008;
   localparam logic [APB_ADDR_W-1:0] CTRL    = 13'h00C;
   localparam logic [APB_ADDR_W-1:0] STT     = 13'h010;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_state_e;

   // Word accesses only: any set bit in the byte offset makes the address unusable.
   function automatic logic addr_misaligned(input logic [1:0] byte_offset);
      return byte_offset != 2'b00;
   endfunction

endpackage

// File: rtl/apb_master_if.sv
// Bundles the command, response and APB wires of the requester so they travel
// as one port. The master modport is the requester's view; the slave modport
// is the view of whoever sits around it (command source, completer, bench).
interface apb_master_if
   import apb_pkg::*;
#(
   parameter int ADDR_W = APB_ADDR_W,
   parameter int DATA_W = APB_DATA_W
) ();

   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_write;
   logic [ADDR_W-1:0]     cmd_addr;
   logic [DATA_W-1:0]     cmd_wdata;
   logic [DATA_W/8-1:0]   cmd_strb;

   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_W-1:0]     rsp_rdata;
   logic                  rsp_err;
   logic                  rsp_timeout;

   logic                  psel;
   logic                  penable;
   logic                  pwrite;
   logic [ADDR_W-1:0]     paddr;
   logic [DATA_W-1:0]     pwdata;
   logic [DATA_W/8-1:0]   pstrb;
   logic                  pready;
   logic [DATA_W-1:0]     prdata;
   logic                  pslverr;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
      output cmd_ready,
      output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
      input  rsp_ready,
      output psel, penable, pwrite, paddr, pwdata, pstrb,
      input  pready, prdata, pslverr
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb,
      input  cmd_ready,
      input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
      output rsp_ready,
      input  psel, penable, pwrite, paddr, pwdata, pstrb,
      output pready, prdata, pslverr
   );

endinterface

// File: rtl/apb_master_timer.sv
// Counts the ACCESS cycles of the current transfer and flags the cycle in
// which the limit is reached. A limit of 0 means wait forever.
module apb_master_timer
   import apb_pkg::*;
#(
   parameter int TIMEOUT = APB_TIMEOUT
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   // count_q holds (ACCESS cycle number - 1), so it only has to reach TIMEOUT-1.
   localparam int               CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic             at_last;

   // Next count: clear wins, otherwise advance while enabled and saturate at the limit.
   always_comb begin
      at_last = (count_q == LAST);
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && !at_last) begin
         count_d = count_q + 1'b1;
      end
   end

   assign expired = (TIMEOUT != 0) && enable && !clear && at_last;

   // Counter register; reset drops any partial count of an aborted transfer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/apb_master.sv
// APB requester: accepts one command at a time, runs the SETUP/ACCESS bus
// phases, and returns read data, slave error or timeout on the response
// channel. All outputs are registered and forced low by reset.
module apb_master
   import apb_pkg::*;
#(
   parameter int ADDR_W  = APB_ADDR_W,
   parameter int DATA_W  = APB_DATA_W,
   parameter int TIMEOUT = APB_TIMEOUT
) (
   input  logic           pclk,
   input  logic           preset,
   apb_master_if.master   bus
);

   localparam int STRB_W = DATA_W / 8;

   apb_state_e          state_q;
   apb_state_e          state_d;

   logic                cmd_ready_q;
   logic                cmd_ready_d;
   logic                psel_q;
   logic                psel_d;
   logic                penable_q;
   logic                penable_d;
   logic                pwrite_q;
   logic                pwrite_d;
   logic [ADDR_W-1:0]   paddr_q;
   logic [ADDR_W-1:0]   paddr_d;
   logic [DATA_W-1:0]   pwdata_q;
   logic [DATA_W-1:0]   pwdata_d;
   logic [STRB_W-1:0]   pstrb_q;
   logic [STRB_W-1:0]   pstrb_d;
   logic                rsp_valid_q;
   logic                rsp_valid_d;
   logic [DATA_W-1:0]   rsp_rdata_q;
   logic [DATA_W-1:0]   rsp_rdata_d;
   logic                rsp_err_q;
   logic                rsp_err_d;
   logic                rsp_timeout_q;
   logic                rsp_timeout_d;

   logic                timer_clear;
   logic                timer_enable;
   logic                timer_expired;

   // The timer only runs during ACCESS and restarts from zero on every new transfer.
   assign timer_enable = (state_q == ACCESS);
   assign timer_clear  = (state_q != ACCESS);

   apb_master_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_timer (
      .clk     (pclk),
      .rst     (preset),
      .clear   (timer_clear),
      .enable  (timer_enable),
      .expired (timer_expired)
   );

   // Next state and next output values; outputs are decoded from the next state so they are registered.
   always_comb begin
      state_d       = state_q;
      pwrite_d      = pwrite_q;
      paddr_d       = paddr_q;
      pwdata_d      = pwdata_q;
      pstrb_d       = pstrb_q;
      rsp_rdata_d   = rsp_rdata_q;
      rsp_err_d     = rsp_err_q;
      rsp_timeout_d = rsp_timeout_q;

      case (state_q)
         IDLE: begin
            if (bus.cmd_valid && cmd_ready_q) begin
               if (addr_misaligned(bus.cmd_addr[1:0])) begin
                  // Bad address never reaches the bus; the bus fields keep their old values.
                  state_d       = RESP;
                  rsp_rdata_d   = '0;
                  rsp_err_d     = 1'b1;
                  rsp_timeout_d = 1'b0;
               end else begin
                  state_d  = SETUP;
                  pwrite_d = bus.cmd_write;
                  paddr_d  = bus.cmd_addr;
                  pwdata_d = bus.cmd_write ? bus.cmd_wdata : '0;
                  pstrb_d  = bus.cmd_write ? bus.cmd_strb  : '0;
               end
            end
         end

         SETUP: begin
            state_d = ACCESS;
         end

         ACCESS: begin
            if (bus.pready) begin
               state_d       = RESP;
               rsp_rdata_d   = pwrite_q ? '0 : bus.prdata;
               rsp_err_d     = bus.pslverr;
               rsp_timeout_d = 1'b0;
            end else if (timer_expired) begin
               state_d       = RESP;
               rsp_rdata_d   = '0;
               rsp_err_d     = 1'b1;
               rsp_timeout_d = 1'b1;
            end
         end

         RESP: begin
            if (bus.rsp_ready) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      cmd_ready_d = (state_d == IDLE);
      psel_d      = (state_d == SETUP) || (state_d == ACCESS);
      penable_d   = (state_d == ACCESS);
      rsp_valid_d = (state_d == RESP);
   end

   // State and output registers; reset clears everything, dropping psel/penable without waiting for a clock.
   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         state_q       <= IDLE;
         cmd_ready_q   <= 1'b0;
         psel_q        <= 1'b0;
         penable_q     <= 1'b0;
         pwrite_q      <= 1'b0;
         paddr_q       <= '0;
         pwdata_q      <= '0;
         pstrb_q       <= '0;
         rsp_valid_q   <= 1'b0;
         rsp_rdata_q   <= '0;
         rsp_err_q     <= 1'b0;
         rsp_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cmd_ready_q   <= cmd_ready_d;
         psel_q        <= psel_d;
         penable_q     <= penable_d;
         pwrite_q      <= pwrite_d;
         paddr_q       <= paddr_d;
         pwdata_q      <= pwdata_d;
         pstrb_q       <= pstrb_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_rdata_q   <= rsp_rdata_d;
         rsp_err_q     <= rsp_err_d;
         rsp_timeout_q <= rsp_timeout_d;
      end
   end

   assign bus.cmd_ready   = cmd_ready_q;
   assign bus.psel        = psel_q;
   assign bus.penable     = penable_q;
   assign bus.pwrite      = pwrite_q;
   assign bus.paddr       = paddr_q;
   assign bus.pwdata      = pwdata_q;
   assign bus.pstrb       = pstrb_q;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_rdata   = rsp_rdata_q;
   assign bus.rsp_err     = rsp_err_q;
   assign bus.rsp_timeout = rsp_timeout_q;

endmodule
